// File: rtl/router_fsm_ctrl_if.sv
// Handshake bundle between the 1x3 router controller and its register block / FIFOs.
interface router_fsm_ctrl_if;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] soft_reset;
  logic       parity_done;
  logic       low_pkt_valid;
  logic       write_enb_reg;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic       busy;
  logic [1:0] sel_addr;
  logic       wait_timeout;

  modport master (
    output pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid,
    input  write_enb_reg, detect_add, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, busy, sel_addr, wait_timeout
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, fifo_empty, soft_reset, parity_done, low_pkt_valid,
    output write_enb_reg, detect_add, lfd_state, ld_state, laf_state, full_state,
           rst_int_reg, busy, sel_addr, wait_timeout
  );
endinterface

// File: rtl/router_fsm_ctrl.sv
// Moore sequencer for the 1x3 router register datapath: header decode, payload, parity,
// FIFO-full stall and an optional bounded wait for the destination FIFO to drain.
//
// state              | meaning
// DECODE_ADDRESS     | idle, waiting for a header byte
// LOAD_FIRST_DATA    | header byte written to the selected FIFO
// LOAD_DATA          | payload bytes streaming
// LOAD_PARITY        | parity byte written
// FIFO_FULL_STATE    | stalled, selected FIFO full
// LOAD_AFTER_FULL    | flush the byte held during the stall
// WAIT_TILL_EMPTY    | destination FIFO still holds an old packet
// CHECK_PARITY_ERROR | compare parity, clear internal registers
module router_fsm_ctrl #(
  parameter int WAIT_LIMIT = 0,
  parameter int CNT_W      = 8
) (
  input  logic             clock,
  input  logic             reset,
  router_fsm_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } state_e;

  localparam logic [CNT_W-1:0] LIMIT_M1 = (WAIT_LIMIT == 0) ? '0 : CNT_W'(WAIT_LIMIT - 1);

  state_e           state, state_nxt;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic [1:0]       sel_addr;
  logic             timeout, timeout_nxt;
  logic [3:0]       empty_ext, srst_ext;
  logic             addr_ok, hdr_take, empty_hdr, empty_sel, srst_sel;

  // Pad to four entries so address 3 indexes a defined 0 rather than falling off the vector.
  assign empty_ext = {1'b0, bus.fifo_empty};
  assign srst_ext  = {1'b0, bus.soft_reset};
  assign addr_ok   = (bus.data_in != 2'd3);
  assign hdr_take  = (state == DECODE_ADDRESS) && bus.pkt_valid && addr_ok;
  assign empty_hdr = empty_ext[bus.data_in];
  assign empty_sel = empty_ext[sel_addr];
  assign srst_sel  = srst_ext[sel_addr];

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= DECODE_ADDRESS;
      wait_cnt <= '0;
      sel_addr <= 2'd0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      timeout  <= timeout_nxt;
      if (hdr_take) sel_addr <= bus.data_in;
    end
  end

  always_comb begin
    state_nxt    = state;
    timeout_nxt  = 1'b0;
    wait_cnt_nxt = '0;
    if (state != DECODE_ADDRESS && srst_sel) begin
      state_nxt = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS:
          if (hdr_take) state_nxt = empty_hdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        LOAD_FIRST_DATA:
          state_nxt = LOAD_DATA;
        LOAD_DATA:
          if (bus.fifo_full)       state_nxt = FIFO_FULL_STATE;
          else if (!bus.pkt_valid) state_nxt = LOAD_PARITY;
        FIFO_FULL_STATE:
          if (!bus.fifo_full) state_nxt = LOAD_AFTER_FULL;
        LOAD_AFTER_FULL:
          if (bus.parity_done)        state_nxt = DECODE_ADDRESS;
          else if (bus.low_pkt_valid) state_nxt = LOAD_PARITY;
          else                        state_nxt = LOAD_DATA;
        LOAD_PARITY:
          state_nxt = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR:
          state_nxt = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY:
          if (empty_sel) begin
            state_nxt = LOAD_FIRST_DATA;
          end else if (WAIT_LIMIT != 0 && wait_cnt == LIMIT_M1) begin
            state_nxt   = DECODE_ADDRESS;
            timeout_nxt = 1'b1;
          end
        default:
          state_nxt = DECODE_ADDRESS;
      endcase
    end
    // Counter only runs while staying in WAIT_TILL_EMPTY; saturates instead of wrapping.
    if (state == WAIT_TILL_EMPTY && state_nxt == WAIT_TILL_EMPTY)
      wait_cnt_nxt = (wait_cnt == '1) ? wait_cnt : wait_cnt + CNT_W'(1);
  end

  always_comb begin
    bus.detect_add    = (state == DECODE_ADDRESS);
    bus.lfd_state     = (state == LOAD_FIRST_DATA);
    bus.ld_state      = (state == LOAD_DATA);
    bus.laf_state     = (state == LOAD_AFTER_FULL);
    bus.full_state    = (state == FIFO_FULL_STATE);
    bus.rst_int_reg   = (state == CHECK_PARITY_ERROR);
    bus.write_enb_reg = (state == LOAD_DATA) || (state == LOAD_PARITY) ||
                        (state == LOAD_AFTER_FULL);
    bus.busy          = !((state == DECODE_ADDRESS) || (state == LOAD_DATA));
  end

  assign bus.sel_addr     = sel_addr;
  assign bus.wait_timeout = timeout;

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Directed bench for router_fsm_ctrl: one cycle per table row, plus wait-timeout sequences
// on a second instance built with WAIT_LIMIT=3.
module tb_router_fsm_ctrl;

  typedef enum logic [2:0] {S_DA, S_LFD, S_LD, S_LP, S_FFS, S_LAF, S_WTE, S_CPE} st_e;

  typedef struct {
    bit       rst;
    bit       pv;
    bit [1:0] din;
    bit       full;
    bit [2:0] empty;
    bit [2:0] srst;
    bit       pd;
    bit       lpv;
    st_e      st;
    bit [1:0] sel;
    bit       to;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t vq[$];

  always #5 clock = ~clock;

  router_fsm_ctrl_if bus ();
  router_fsm_ctrl_if bus_t ();

  assign bus_t.pkt_valid     = bus.pkt_valid;
  assign bus_t.data_in       = bus.data_in;
  assign bus_t.fifo_full     = bus.fifo_full;
  assign bus_t.fifo_empty    = bus.fifo_empty;
  assign bus_t.soft_reset    = bus.soft_reset;
  assign bus_t.parity_done   = bus.parity_done;
  assign bus_t.low_pkt_valid = bus.low_pkt_valid;

  router_fsm_ctrl #(.WAIT_LIMIT(0), .CNT_W(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  router_fsm_ctrl #(.WAIT_LIMIT(3), .CNT_W(8)) dut_t (
    .clock (clock),
    .reset (reset),
    .bus   (bus_t)
  );

  logic [10:0] act_m, act_t;
  assign act_m = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state, bus.full_state,
                  bus.rst_int_reg, bus.write_enb_reg, bus.busy, bus.sel_addr, bus.wait_timeout};
  assign act_t = {bus_t.detect_add, bus_t.lfd_state, bus_t.ld_state, bus_t.laf_state,
                  bus_t.full_state, bus_t.rst_int_reg, bus_t.write_enb_reg, bus_t.busy,
                  bus_t.sel_addr, bus_t.wait_timeout};

  // Output order: detect, lfd, ld, laf, full, rst_int, wen, busy | sel_addr | wait_timeout
  function automatic logic [10:0] exp_vec(st_e s, bit [1:0] sel, bit to);
    logic [7:0] o;
    case (s)
      S_DA:    o = 8'b1000_0000;
      S_LFD:   o = 8'b0100_0001;
      S_LD:    o = 8'b0010_0010;
      S_LP:    o = 8'b0000_0011;
      S_FFS:   o = 8'b0000_1001;
      S_LAF:   o = 8'b0001_0011;
      S_WTE:   o = 8'b0000_0001;
      S_CPE:   o = 8'b0000_0101;
      default: o = 8'b0000_0000;
    endcase
    return {o, sel, to};
  endfunction

  function automatic vec_t mk(int rst, int pv, int din, int full, int empty, int srst,
                              int pd, int lpv, st_e st, int sel, int to);
    vec_t v;
    v.rst   = 1'(rst);
    v.pv    = 1'(pv);
    v.din   = 2'(din);
    v.full  = 1'(full);
    v.empty = 3'(empty);
    v.srst  = 3'(srst);
    v.pd    = 1'(pd);
    v.lpv   = 1'(lpv);
    v.st    = st;
    v.sel   = 2'(sel);
    v.to    = 1'(to);
    return v;
  endfunction

  task automatic apply(vec_t v);
    reset             = v.rst;
    bus.pkt_valid     = v.pv;
    bus.data_in       = v.din;
    bus.fifo_full     = v.full;
    bus.fifo_empty    = v.empty;
    bus.soft_reset    = v.srst;
    bus.parity_done   = v.pd;
    bus.low_pkt_valid = v.lpv;
    @(posedge clock);
    #1;
  endtask

  task automatic check(string name, int idx, logic [10:0] act, logic [10:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %b required %b (det,lfd,ld,laf,full,rst_int,wen,busy,sel,to)",
               name, idx, act, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset             = 1'b1;
    bus.pkt_valid     = 1'b0;
    bus.data_in       = 2'd0;
    bus.fifo_full     = 1'b0;
    bus.fifo_empty    = 3'b111;
    bus.soft_reset    = 3'b000;
    bus.parity_done   = 1'b0;
    bus.low_pkt_valid = 1'b0;

    //            rst pv din full emp srst pd lpv  state  sel to
    // reset and idle
    vq.push_back(mk(1, 0, 0, 0, 7, 0, 0, 0, S_DA,  0, 0));
    vq.push_back(mk(1, 0, 0, 0, 7, 0, 0, 0, S_DA,  0, 0));
    vq.push_back(mk(0, 0, 0, 0, 7, 0, 0, 0, S_DA,  0, 0));
    // clean packet to addr 2, three payload bytes
    vq.push_back(mk(0, 1, 2, 0, 7, 0, 0, 0, S_LFD, 2, 0));
    vq.push_back(mk(0, 1, 0, 0, 7, 0, 0, 0, S_LD,  2, 0));
    vq.push_back(mk(0, 1, 0, 0, 7, 0, 0, 0, S_LD,  2, 0));
    vq.push_back(mk(0, 1, 0, 0, 7, 0, 0, 0, S_LD,  2, 0));
    vq.push_back(mk(0, 0, 0, 0, 7, 0, 0, 0, S_LP,  2, 0));
    vq.push_back(mk(0, 0, 0, 0, 7, 0, 0, 0, S_CPE, 2, 0));
    vq.push_back(mk(0, 0, 0, 0, 7, 0, 0, 0, S_DA,  2, 0));
    // invalid address 3 is dropped
    vq.push_back(mk(0, 1, 3, 0, 7, 0, 0, 0, S_DA,  2, 0));
    // full stall on 2nd payload byte for 4 cycles, then low_pkt_valid
    vq.push_back(mk(0, 1, 0, 0, 7, 0, 0, 0, S_LFD, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 7, 0, 0, 0, S_LD,  0, 0));
    vq.push_back(mk(0, 1, 0, 1, 7, 0, 0, 0, S_FFS, 0, 0));
    vq.push_back(mk(0, 1, 0, 1, 7, 0, 0, 0, S_FFS, 0, 0));
    vq.push_back(mk(0, 1, 0, 1, 7, 0, 0, 0, S_FFS, 0, 0));
    vq.push_back(mk(0, 1, 0, 1, 7, 0, 0, 0, S_FFS, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 7, 0, 0, 0, S_LAF, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 7, 0, 0, 1, S_LP,  0, 0));
    vq.push_back(mk(0, 0, 0, 0, 7, 0, 0, 0, S_CPE, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 7, 0, 0, 0, S_DA,  0, 0));
    // parity_done beats low_pkt_valid in LOAD_AFTER_FULL
    vq.push_back(mk(0, 1, 1, 0, 7, 0, 0, 0, S_LFD, 1, 0));
    vq.push_back(mk(0, 1, 0, 0, 7, 0, 0, 0, S_LD,  1, 0));
    vq.push_back(mk(0, 1, 0, 1, 7, 0, 0, 0, S_FFS, 1, 0));
    vq.push_back(mk(0, 1, 0, 0, 7, 0, 0, 0, S_LAF, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 7, 0, 1, 1, S_DA,  1, 0));
    // fifo_full beats !pkt_valid in LOAD_DATA; LAF back to LD; CPE with full
    vq.push_back(mk(0, 1, 0, 0, 7, 0, 0, 0, S_LFD, 0, 0));
    vq.push_back(mk(0, 1, 0, 0, 7, 0, 0, 0, S_LD,  0, 0));
    vq.push_back(mk(0, 0, 0, 1, 7, 0, 0, 0, S_FFS, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 7, 0, 0, 0, S_LAF, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 7, 0, 0, 0, S_LD,  0, 0));
    vq.push_back(mk(0, 0, 0, 0, 7, 0, 0, 0, S_LP,  0, 0));
    vq.push_back(mk(0, 0, 0, 1, 7, 0, 0, 0, S_CPE, 0, 0));
    vq.push_back(mk(0, 0, 0, 1, 7, 0, 0, 0, S_FFS, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 7, 0, 0, 0, S_LAF, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 7, 0, 1, 0, S_DA,  0, 0));
    // soft reset: other channel ignored, selected channel aborts
    vq.push_back(mk(0, 1, 2, 0, 7, 0, 0, 0, S_LFD, 2, 0));
    vq.push_back(mk(0, 1, 0, 0, 7, 0, 0, 0, S_LD,  2, 0));
    vq.push_back(mk(0, 1, 0, 0, 7, 1, 0, 0, S_LD,  2, 0));
    vq.push_back(mk(0, 1, 0, 0, 7, 4, 0, 0, S_DA,  2, 0));
    vq.push_back(mk(0, 0, 0, 0, 7, 4, 0, 0, S_DA,  2, 0));
    // mid-packet reset
    vq.push_back(mk(0, 1, 1, 0, 7, 0, 0, 0, S_LFD, 1, 0));
    vq.push_back(mk(1, 1, 0, 0, 7, 0, 0, 0, S_DA,  0, 0));
    // addr 1 busy for 5 cycles, unlimited wait
    vq.push_back(mk(0, 1, 1, 0, 5, 0, 0, 0, S_WTE, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 5, 0, 0, 0, S_WTE, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 5, 0, 0, 0, S_WTE, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 5, 0, 0, 0, S_WTE, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 5, 0, 0, 0, S_WTE, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 7, 0, 0, 0, S_LFD, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 7, 0, 0, 0, S_LD,  1, 0));
    vq.push_back(mk(0, 0, 0, 0, 7, 0, 0, 0, S_LP,  1, 0));
    vq.push_back(mk(0, 0, 0, 0, 7, 0, 0, 0, S_CPE, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 7, 0, 0, 0, S_DA,  1, 0));
    // soft reset of the selected channel while waiting
    vq.push_back(mk(0, 1, 0, 0, 6, 0, 0, 0, S_WTE, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 6, 1, 0, 0, S_DA,  0, 0));

    foreach (vq[i]) begin
      apply(vq[i]);
      check("table", i, act_m, exp_vec(vq[i].st, vq[i].sel, vq[i].to));
    end

    // WAIT_LIMIT=3: three cycles waiting, then a one-cycle timeout pulse back in DECODE
    apply(mk(1, 0, 0, 0, 7, 0, 0, 0, S_DA, 0, 0));
    check("to_reset", 0, act_t, exp_vec(S_DA, 0, 0));
    apply(mk(0, 1, 1, 0, 5, 0, 0, 0, S_WTE, 1, 0));
    check("to_wait", 1, act_t, exp_vec(S_WTE, 1, 0));
    apply(mk(0, 0, 0, 0, 5, 0, 0, 0, S_WTE, 1, 0));
    check("to_wait", 2, act_t, exp_vec(S_WTE, 1, 0));
    apply(mk(0, 0, 0, 0, 5, 0, 0, 0, S_WTE, 1, 0));
    check("to_wait", 3, act_t, exp_vec(S_WTE, 1, 0));
    apply(mk(0, 0, 0, 0, 5, 0, 0, 0, S_DA, 1, 1));
    check("to_pulse", 4, act_t, exp_vec(S_DA, 1, 1));
    check("nolimit_wait", 4, act_m, exp_vec(S_WTE, 1, 0));
    apply(mk(0, 0, 0, 0, 5, 0, 0, 0, S_DA, 1, 0));
    check("to_clear", 5, act_t, exp_vec(S_DA, 1, 0));
    apply(mk(0, 0, 0, 0, 7, 0, 0, 0, S_LFD, 1, 0));
    check("nolimit_drain", 6, act_m, exp_vec(S_LFD, 1, 0));

    // FIFO drains on the last allowed cycle: drain wins over the timeout
    apply(mk(1, 0, 0, 0, 7, 0, 0, 0, S_DA, 0, 0));
    apply(mk(0, 1, 2, 0, 3, 0, 0, 0, S_WTE, 2, 0));
    check("edge_wait", 1, act_t, exp_vec(S_WTE, 2, 0));
    apply(mk(0, 0, 0, 0, 3, 0, 0, 0, S_WTE, 2, 0));
    apply(mk(0, 0, 0, 0, 3, 0, 0, 0, S_WTE, 2, 0));
    check("edge_wait", 3, act_t, exp_vec(S_WTE, 2, 0));
    apply(mk(0, 0, 0, 0, 7, 0, 0, 0, S_LFD, 2, 0));
    check("edge_drain", 4, act_t, exp_vec(S_LFD, 2, 0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
